// File: rtl/ofdm_remove_cp_var.sv
// ---------------------------------------------------------------------------
// ofdm_remove_cp_var
//   Strips a runtime-variable cyclic prefix from a stream of complex OFDM
//   samples. Each symbol is cp+N valid samples. The first cp-off are
//   discarded, the next N are passed as the FFT window, and the last off are
//   discarded. off moves the FFT window back into the CP.
//
// Ports
//   i_clk            rising-edge clock
//   i_reset          asynchronous active-high reset
//   i_valid          input sample strobe; low holds all state
//   in_data_i/_q     input sample (I/Q)
//   i_frame_sync     current valid sample is CP sample 0
//   i_cp_len         runtime CP length (clamped to CP_MAX)
//   i_fft_offset     CP samples kept ahead of the FFT window (clamped to cp)
//   out_valid        output sample strobe (1-cycle latency)
//   out_data_i/_q    output sample, holds when out_valid=0
//   out_sym_start    first window sample of a symbol
//   out_sym_last     Nth window sample of a symbol
//   out_sym_cnt      symbols completed since the last frame sync
//   o_sync_err       pulse on a frame sync that is off a symbol boundary
// ---------------------------------------------------------------------------
module ofdm_remove_cp_var #(
   parameter int DATA_SIZE    = 16,
   parameter int SYMBOLS_SIZE = 256,
   parameter int CP_MAX       = 64,
   parameter int CPW          = $clog2(CP_MAX + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_valid,
   input  logic [DATA_SIZE-1:0] in_data_i,
   input  logic [DATA_SIZE-1:0] in_data_q,
   input  logic                 i_frame_sync,
   input  logic [CPW-1:0]       i_cp_len,
   input  logic [CPW-1:0]       i_fft_offset,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data_i,
   output logic [DATA_SIZE-1:0] out_data_q,
   output logic                 out_sym_start,
   output logic                 out_sym_last,
   output logic [15:0]          out_sym_cnt,
   output logic                 o_sync_err
);

   // Counter must index N window samples and hold a full CP length.
   localparam int CNTMAX = (SYMBOLS_SIZE > CP_MAX + 1) ? SYMBOLS_SIZE : (CP_MAX + 1);
   localparam int CNTW   = $clog2(CNTMAX);

   localparam logic [CNTW-1:0] PASS_LAST = CNTW'(SYMBOLS_SIZE - 1);
   localparam logic [CPW-1:0]  CP_LIM    = CPW'(CP_MAX);

   typedef enum logic [1:0] {
      IDLE,
      SKIP,
      PASS,
      TAIL
   } state_t;

   state_t              state_q, state_d, cls;
   logic [CNTW-1:0]     cnt_q, cnt_d, idx, skip_last, tail_last;
   logic [CPW-1:0]      cp_q, cp_d, off_q, off_d;
   logic [CPW-1:0]      cp_in, off_in, cp_cur, off_cur, skip_len;
   logic                sync, at_bnd, sample0;
   logic                pass_hit, start_hit, last_hit, err_hit;
   logic [15:0]         sym_cnt_q, sym_cnt_d;

   logic                 valid_q, start_q, last_q, err_q;
   logic [DATA_SIZE-1:0] dout_i_q, dout_q_q;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   // state_q/cnt_q describe the next valid sample. SKIP with cnt_q=0 is
   // reachable only as the end-of-symbol marker: a CP sample 0 always
   // leaves SKIP with cnt 1 or moves on to PASS. So that encoding doubles
   // as the automatic boundary flag. The cp/off for the sample being
   // classified come straight from the ports on a CP sample 0. This lets
   // sample 0 pass in its own cycle when cp-off=0.
   always_comb begin : next_state_logic
      sync      = i_valid & i_frame_sync;
      at_bnd    = (state_q == SKIP) && (cnt_q == '0);
      sample0   = sync | (i_valid & at_bnd);
      cp_in     = (i_cp_len > CP_LIM) ? CP_LIM : i_cp_len;
      off_in    = (i_fft_offset > cp_in) ? cp_in : i_fft_offset;
      cp_cur    = sample0 ? cp_in  : cp_q;
      off_cur   = sample0 ? off_in : off_q;
      skip_len  = cp_cur - off_cur;
      skip_last = CNTW'(skip_len) - CNTW'(1);
      tail_last = CNTW'(off_cur) - CNTW'(1);

      if (sample0) begin
         cls = (skip_len == '0) ? PASS : SKIP;
         idx = '0;
      end else begin
         cls = state_q;
         idx = cnt_q;
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      cp_d    = cp_q;
      off_d   = off_q;

      if (i_valid) begin
         cp_d  = cp_cur;
         off_d = off_cur;
         unique case (cls)
            IDLE: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
            SKIP: begin
               if (idx == skip_last) begin
                  state_d = PASS;
                  cnt_d   = '0;
               end else begin
                  state_d = SKIP;
                  cnt_d   = idx + CNTW'(1);
               end
            end
            PASS: begin
               if (idx == PASS_LAST) begin
                  state_d = (off_cur == '0) ? SKIP : TAIL;
                  cnt_d   = '0;
               end else begin
                  state_d = PASS;
                  cnt_d   = idx + CNTW'(1);
               end
            end
            TAIL: begin
               if (idx == tail_last) begin
                  state_d = SKIP;
                  cnt_d   = '0;
               end else begin
                  state_d = TAIL;
                  cnt_d   = idx + CNTW'(1);
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Output decode
   // ------------------------------------------------------------------
   always_comb begin : output_logic
      pass_hit  = i_valid && (cls == PASS);
      start_hit = pass_hit && (idx == '0);
      last_hit  = pass_hit && (idx == PASS_LAST);
      err_hit   = sync && (state_q != IDLE) && !at_bnd;
      sym_cnt_d = sym_cnt_q;
      if (sync) begin
         sym_cnt_d = '0;
      end else if (last_hit) begin
         sym_cnt_d = sym_cnt_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin : state_reg
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cp_q    <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cp_q    <= cp_d;
         off_q   <= off_d;
      end
   end

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_reset) begin : out_reg
      if (i_reset) begin
         valid_q   <= 1'b0;
         start_q   <= 1'b0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
         dout_i_q  <= '0;
         dout_q_q  <= '0;
         sym_cnt_q <= '0;
      end else begin
         valid_q   <= pass_hit;
         start_q   <= start_hit;
         last_q    <= last_hit;
         err_q     <= err_hit;
         sym_cnt_q <= sym_cnt_d;
         if (pass_hit) begin
            dout_i_q <= in_data_i;
            dout_q_q <= in_data_q;
         end
      end
   end

   assign out_valid     = valid_q;
   assign out_data_i    = dout_i_q;
   assign out_data_q    = dout_q_q;
   assign out_sym_start = start_q;
   assign out_sym_last  = last_q;
   assign out_sym_cnt   = sym_cnt_q;
   assign o_sync_err    = err_q;

endmodule

// File: tb/tb_ofdm_remove_cp_var.sv
// ---------------------------------------------------------------------------
// tb_ofdm_remove_cp_var
//   Self-checking bench for ofdm_remove_cp_var with N=16, CP_MAX=8.
//   in_data_i carries the running index of valid samples.
//   A position-based model pushes the expected output records into a queue
//   as samples are driven. A negedge monitor pops and compares them.
//   Table vectors also carry hand-derived totals.
// ---------------------------------------------------------------------------
module tb_ofdm_remove_cp_var;

   localparam int DW  = 16;
   localparam int N   = 16;
   localparam int CPM = 8;
   localparam int CPW = $clog2(CPM + 1);

   logic           clk, rst;
   logic           i_valid, i_frame_sync;
   logic [DW-1:0]  in_data_i, in_data_q;
   logic [CPW-1:0] i_cp_len, i_fft_offset;
   logic           out_valid, out_sym_start, out_sym_last, o_sync_err;
   logic [DW-1:0]  out_data_i, out_data_q;
   logic [15:0]    out_sym_cnt;

   ofdm_remove_cp_var #(
      .DATA_SIZE   (DW),
      .SYMBOLS_SIZE(N),
      .CP_MAX      (CPM)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .i_valid      (i_valid),
      .in_data_i    (in_data_i),
      .in_data_q    (in_data_q),
      .i_frame_sync (i_frame_sync),
      .i_cp_len     (i_cp_len),
      .i_fft_offset (i_fft_offset),
      .out_valid    (out_valid),
      .out_data_i   (out_data_i),
      .out_data_q   (out_data_q),
      .out_sym_start(out_sym_start),
      .out_sym_last (out_sym_last),
      .out_sym_cnt  (out_sym_cnt),
      .o_sync_err   (o_sync_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cp_len;
      int off;
      bit toggle;
      int nsamp;
      int exp_npass;
      int exp_first;
      int exp_symcnt;
   } vec_t;

   typedef struct {
      logic [15:0] di;
      logic [15:0] dq;
      bit          st;
      bit          la;
      logic [15:0] cnt;
      int          cyc;
   } exp_t;

   exp_t q[$];

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;
   int n_err    = 0;
   int first_di = -1;

   // model state
   int          idx   = 0;
   bit          m_act = 0;
   int          m_pos = 0;
   int          m_cp  = 0;
   int          m_off = 0;
   logic [15:0] m_cnt = '0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid) begin
            if (n_out == 0) first_di = int'(out_data_i);
            n_out++;
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_out: got data_i %0d expected no output", out_data_i);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("out_data_i", out_data_i, e.di);
               chk("out_data_q", out_data_q, e.dq);
               chk("out_sym_start", out_sym_start, e.st);
               chk("out_sym_last", out_sym_last, e.la);
               chk("out_sym_cnt", out_sym_cnt, e.cnt);
               chk("out_latency_cycle", cyc, e.cyc);
            end
         end else begin
            chk("idle_start_low", out_sym_start, 0);
            chk("idle_last_low", out_sym_last, 0);
         end
         if (o_sync_err) n_err++;
      end
   end

   // Drive one cycle of inputs and advance the model.
   task automatic step(input bit v, input bit s, input int cp, input int off);
      int rel;
      @(posedge clk);
      #1;
      i_valid      = v;
      i_frame_sync = s;
      i_cp_len     = CPW'(cp);
      i_fft_offset = CPW'(off);
      in_data_i    = v ? 16'(idx) : 16'hDEAD;
      in_data_q    = v ? (16'(idx) ^ 16'h5A5A) : 16'hBEEF;
      if (v) begin
         if (s) begin
            m_act = 1;
            m_pos = 0;
            m_cnt = '0;
         end
         if (m_act) begin
            if (m_pos == 0) begin
               m_cp  = (cp > CPM) ? CPM : cp;
               m_off = (off > m_cp) ? m_cp : off;
            end
            rel = m_pos - (m_cp - m_off);
            if (rel >= 0 && rel < N) begin
               exp_t e;
               if (rel == N - 1) m_cnt = m_cnt + 16'd1;
               e.di  = 16'(idx);
               e.dq  = 16'(idx) ^ 16'h5A5A;
               e.st  = (rel == 0);
               e.la  = (rel == N - 1);
               e.cnt = m_cnt;
               e.cyc = cyc + 1;
               q.push_back(e);
            end
            m_pos++;
            if (m_pos == m_cp + N) m_pos = 0;
         end
         idx++;
      end
   endtask

   task automatic drain();
      repeat (3) step(0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data_i"}, out_data_i, 0);
      chk({tag, "_data_q"}, out_data_q, 0);
      chk({tag, "_start"}, out_sym_start, 0);
      chk({tag, "_last"}, out_sym_last, 0);
      chk({tag, "_cnt"}, out_sym_cnt, 0);
      chk({tag, "_err"}, o_sync_err, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      i_valid      = 1'b0;
      i_frame_sync = 1'b0;
      #1;
      check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      q.delete();
      m_act    = 0;
      m_pos    = 0;
      idx      = 0;
      n_out    = 0;
      n_err    = 0;
      first_di = -1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   vec_t vecs[6];

   initial begin
      rst          = 1'b1;
      i_valid      = 1'b0;
      i_frame_sync = 1'b0;
      in_data_i    = '0;
      in_data_q    = '0;
      i_cp_len     = '0;
      i_fft_offset = '0;

      //            cp  off tog nsamp npass first symcnt
      vecs[0] = '{  4,  0,  0,  40,   32,   4,    2 };
      vecs[1] = '{  4,  2,  0,  40,   32,   2,    2 };
      vecs[2] = '{  0,  3,  0,  32,   32,   0,    2 };
      vecs[3] = '{ 12,  0,  0,  48,   32,   8,    2 };
      vecs[4] = '{  4,  0,  1,  40,   32,   4,    2 };
      vecs[5] = '{  8,  8,  0,  48,   32,   0,    2 };

      repeat (2) @(posedge clk);

      for (int v = 0; v < 6; v++) begin
         do_reset();
         for (int k = 0; k < vecs[v].nsamp; k++) begin
            if (vecs[v].toggle && k > 0) step(0, 0, vecs[v].cp_len, vecs[v].off);
            step(1, (k == 0), vecs[v].cp_len, vecs[v].off);
         end
         drain();
         chk("vec_npass", n_out, vecs[v].exp_npass);
         chk("vec_first", first_di, vecs[v].exp_first);
         chk("vec_symcnt", out_sym_cnt, vecs[v].exp_symcnt);
         chk("vec_no_err", n_err, 0);
      end

      // Sync at PASS index 5 of the second symbol (input 29).
      do_reset();
      for (int k = 0; k < 29; k++) step(1, (k == 0), 4, 0);
      step(1, 1, 4, 0);
      step(0, 0, 4, 0);
      @(negedge clk);
      chk("abort_err_pulse", o_sync_err, 1);
      chk("abort_cnt_cleared", out_sym_cnt, 0);
      for (int k = 30; k < 49; k++) step(1, 0, 4, 0);
      drain();
      chk("abort_err_count", n_err, 1);
      chk("abort_npass", n_out, 37);
      chk("abort_symcnt", out_sym_cnt, 1);

      // Sync exactly on the automatic boundary (input 20).
      do_reset();
      for (int k = 0; k < 40; k++) step(1, (k == 0 || k == 20), 4, 0);
      drain();
      chk("bnd_err_count", n_err, 0);
      chk("bnd_npass", n_out, 32);
      chk("bnd_symcnt", out_sym_cnt, 1);

      // Reset mid-PASS, then unsynced data is dropped.
      do_reset();
      for (int k = 0; k < 11; k++) step(1, (k == 0), 4, 0);
      @(negedge clk);
      #1;
      rst     = 1'b1;
      i_valid = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      q.delete();
      m_act = 0;
      m_pos = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst   = 1'b0;
      n_out = 0;
      for (int k = 0; k < 30; k++) step(1, 0, 4, 0);
      drain();
      chk("post_rst_dropped", n_out, 0);
      for (int k = 0; k < 20; k++) step(1, (k == 0), 4, 0);
      drain();
      chk("post_rst_resync_npass", n_out, 16);
      chk("post_rst_symcnt", out_sym_cnt, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ofdm_remove_cp_var.md
OFDM_REMOVE_CP_VAR -- requirements
Module: ofdm_remove_cp_var

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 16: I and Q sample width in bits.
REQ-002 SHALL have parameter SYMBOLS_SIZE, default 256: FFT length N (power of two, at least 4).
REQ-003 SHALL have parameter CP_MAX, default 64: largest supported cyclic prefix (CP) length (at least 1); CPW = $clog2(CP_MAX+1).
REQ-004 SHALL have ports i_clk (in, 1): single clock; all logic on the rising edge.
REQ-005 SHALL have port i_reset (in, 1): reset, asynchronous, active-high.
REQ-006 SHALL have port i_valid (in, 1): input sample strobe.
REQ-007 SHALL have ports in_data_i / in_data_q (in, DATA_SIZE each): input sample.
REQ-008 SHALL have port i_frame_sync (in, 1): marks the current sample as CP sample 0; ignored when i_valid=0.
REQ-009 SHALL have port i_cp_len (in, CPW): runtime CP length.
REQ-010 SHALL have port i_fft_offset (in, CPW): number of CP samples kept ahead of the FFT window (timing-advance back-off).
REQ-011 SHALL have port out_valid (out, 1): output sample strobe.
REQ-012 SHALL have ports out_data_i / out_data_q (out, DATA_SIZE each): output sample.
REQ-013 SHALL have port out_sym_start (out, 1): first output sample of a symbol.
REQ-014 SHALL have port out_sym_last (out, 1): Nth output sample of a symbol.
REQ-015 SHALL have port out_sym_cnt (out, 16): symbols completed since last frame sync; wraps modulo 2^16.
REQ-016 SHALL have port o_sync_err (out, 1): one-cycle pulse on a frame sync that arrives off a symbol boundary.

Function
REQ-017 SHALL implement states IDLE, SKIP, PASS and TAIL; only samples with i_valid=1 advance counters; i_valid=0 holds all state.
REQ-018 SHALL leave IDLE only on i_valid=1 & i_frame_sync=1; valid samples in IDLE are dropped.
REQ-019 SHALL latch, on every CP sample 0 (frame sync or automatic boundary), cp = min(i_cp_len, CP_MAX) and off = min(i_fft_offset, cp); both hold constant for that symbol.
REQ-020 SHALL discard samples 0..cp-off-1 (SKIP), pass samples cp-off..cp-off+N-1 (PASS), and discard the last off samples (TAIL).
REQ-021 SHALL treat a symbol as exactly cp+N valid samples; the next valid sample is automatically CP sample 0 of the next symbol, with no gap and no new sync required.
REQ-022 SHALL skip the SKIP state when cp-off=0, so sample 0 passes in the same cycle as it is counted; SHALL skip TAIL when off=0.
REQ-023 SHALL register outputs with latency exactly 1 cycle: a PASS sample at edge k appears on out_data_* with out_valid=1 after edge k+1; out_data_* hold their last value when out_valid=0.
REQ-024 SHALL assert out_sym_start with PASS index 0 and out_sym_last with PASS index N-1, each qualified by out_valid.
REQ-025 SHALL increment out_sym_cnt in the same cycle out_sym_last is asserted.
REQ-026 SHALL, on a frame sync while not in IDLE, restart at CP sample 0 with that sample and clear out_sym_cnt; the partial symbol is abandoned with no out_sym_last.
REQ-027 SHALL pulse o_sync_err on such a sync unless it falls exactly on an automatic CP-sample-0 boundary.
REQ-028 SHALL give a sync on a boundary sample precedence, with identical latch behaviour and no error pulse.

Reset
REQ-029 SHALL, while i_reset=1, asynchronously force state IDLE, clear all counters and latched cp/off, and drive all outputs to 0.
REQ-030 SHALL, after reset deasserts, produce no output until the first qualified frame sync; reset mid-symbol discards that symbol.

Verification (bench: SYMBOLS_SIZE=16, CP_MAX=8, in_data_i = running index)
REQ-031 SHALL be shown that cp_len=4, off=0, sync on sample 0, continuous valid -> out_valid for inputs 4..19 with start on 4, last on 19; second symbol passes 24..39; out_sym_cnt = 1 then 2.
REQ-032 SHALL be shown that cp_len=4, off=2 -> inputs 2..17 pass, 18..19 dropped, next symbol starts at input 20.
REQ-033 SHALL be shown that cp_len=0, off=3 -> off clamped to 0; inputs 0..15 pass; cp_len=12 is clamped to 8 and 8..23 pass.
REQ-034 SHALL be shown that i_valid toggles 1010... with cp_len=4 -> same output samples as the continuous case, each output 1 cycle after its valid input.
REQ-035 SHALL be shown that a sync at PASS index 5 -> o_sync_err pulses once; out_sym_cnt becomes 0; no out_sym_last for the aborted symbol; new symbol passes cp samples later.
REQ-036 SHALL be shown that reset asserted mid-PASS -> outputs 0 immediately (asynchronously); valid data after release is dropped until the next sync.
